// File: rtl/zigbee_cmd_tx.sv
// Builds a one-byte robot command from the control inputs and sends it as UART 8N1 on change,
// on request, or periodically as a keep-alive.
module zigbee_cmd_tx #(
    parameter int unsigned CLKS_PER_BIT  = 5208,
    parameter int unsigned REPEAT_CYCLES = 2500000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [1:0] mode_sel,
    input  logic [1:0] sub_mode,
    input  logic [1:0] steer,
    input  logic [1:0] drive,
    input  logic [5:0] speed_set,
    input  logic [1:0] func_sel,
    input  logic       send_now,
    output logic       txd,
    output logic       busy,
    output logic [7:0] tx_byte,
    output logic [7:0] frame_cnt
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bit_tmr_q, bit_tmr_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [7:0]    last_sent_q, last_sent_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          pending_q, pending_d;

    logic [7:0] cmd;
    logic       trigger;
    logic       bit_done;

    always_comb begin
        cmd = 8'h00;
        unique case (mode_sel)
            2'b00: cmd = {2'b00, sub_mode, steer, drive};
            2'b01: cmd = {2'b01, speed_set};
            2'b10: cmd = {2'b10, 4'b0000, func_sel};
            2'b11: cmd = 8'hC0;
        endcase
    end

    assign trigger  = (cmd != last_sent_q) || send_now || (rpt_q == RPT_MAX);
    assign bit_done = (bit_tmr_q == BIT_MAX);

    always_comb begin
        state_d     = state_q;
        bit_tmr_d   = bit_tmr_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_byte_d   = tx_byte_q;
        last_sent_d = last_sent_q;
        frame_cnt_d = frame_cnt_q;
        pending_d   = pending_q;
        rpt_d       = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RW'(1);

        if (state_q != StIdle) begin
            bit_tmr_d = bit_done ? '0 : bit_tmr_q + BW'(1);
            // Triggers during a frame collapse into a single follow-up frame.
            if (trigger) pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (trigger || pending_q) begin
                    state_d     = StStart;
                    bit_tmr_d   = '0;
                    bit_idx_d   = 3'd0;
                    shift_d     = cmd;
                    tx_byte_d   = cmd;
                    last_sent_d = cmd;
                    pending_d   = 1'b0;
                    rpt_d       = '0;
                end
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d     = StIdle;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_tmr_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_byte_q   <= 8'h00;
            last_sent_q <= 8'h00;
            frame_cnt_q <= 8'h00;
            rpt_q       <= '0;
            // Forces a frame right after reset even if the command happens to be 0x00.
            pending_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_tmr_q   <= bit_tmr_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_byte_q   <= tx_byte_d;
            last_sent_q <= last_sent_d;
            frame_cnt_q <= frame_cnt_d;
            rpt_q       <= rpt_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            StStart: txd = 1'b0;
            StData:  txd = shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign tx_byte   = tx_byte_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_zigbee_cmd_tx.sv
// Directed bench for zigbee_cmd_tx with short bit and repeat periods; frames are decoded off txd.
module tb_zigbee_cmd_tx;

    localparam int unsigned CLKS  = 4;
    localparam int unsigned RPT   = 100;
    localparam int unsigned FRAME = 10 * CLKS;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [1:0] mode_sel, sub_mode, steer, drive, func_sel;
    logic [5:0] speed_set;
    logic       send_now;
    logic       txd, busy;
    logic [7:0] tx_byte, frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt;

    always #5 clk_50M = ~clk_50M;

    zigbee_cmd_tx #(
        .CLKS_PER_BIT (CLKS),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .mode_sel (mode_sel),
        .sub_mode (sub_mode),
        .steer    (steer),
        .drive    (drive),
        .speed_set(speed_set),
        .func_sel (func_sel),
        .send_now (send_now),
        .txd      (txd),
        .busy     (busy),
        .tx_byte  (tx_byte),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sub;
        logic [1:0] st;
        logic [1:0] dr;
        logic [5:0] spd;
        logic [1:0] fn;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // act: 0 none, 1 change drive to 10 inside data bit 3, 2 pulse send_now three times.
    task automatic wait_frame(input int act, output logic [7:0] b, output bit ok,
                              output int gap);
        logic [FRAME-1:0] lv;
        ok  = 1'b1;
        gap = 0;
        b   = 8'h00;
        while (busy !== 1'b1 && gap < 3 * RPT) begin
            tick();
            gap++;
        end
        if (busy !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (act == 1 && i == 4 * CLKS + 1) drive = 2'b10;
            if (act == 2) send_now = (i == 5 || i == 15 || i == 25);
            if (busy !== 1'b1) ok = 1'b0;
            lv[i] = txd;
            tick();
        end
        send_now = 1'b0;
        if (busy !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CLKS; j++)
                if (lv[k*CLKS+j] !== lv[k*CLKS]) ok = 1'b0;
        if (lv[0] !== 1'b0 || lv[9*CLKS] !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = lv[(k+1)*CLKS];
    endtask

    task automatic set_in(input vec_t v);
        mode_sel  = v.mode;
        sub_mode  = v.sub;
        steer     = v.st;
        drive     = v.dr;
        speed_set = v.spd;
        func_sel  = v.fn;
    endtask

    task automatic quiet(input int n, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b0) seen = 1'b1;
            tick();
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;

        vecs[0] = '{2'b01, 2'b11, 2'b10, 2'b01, 6'd15,  2'b11, 8'h4F};
        vecs[1] = '{2'b00, 2'b01, 2'b10, 2'b10, 6'h3F,  2'b10, 8'h1A};
        vecs[2] = '{2'b10, 2'b01, 2'b01, 2'b01, 6'h2A,  2'b11, 8'h83};
        vecs[3] = '{2'b11, 2'b11, 2'b11, 2'b11, 6'h15,  2'b01, 8'hC0};
        vecs[4] = '{2'b00, 2'b00, 2'b11, 2'b11, 6'h00,  2'b00, 8'h0F};
        vecs[5] = '{2'b01, 2'b00, 2'b00, 2'b00, 6'd63,  2'b00, 8'h7F};
        vecs[6] = '{2'b10, 2'b10, 2'b10, 2'b01, 6'h00,  2'b01, 8'h81};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 2'b10, 6'h3F,  2'b11, 8'h02};

        rst_n    = 1'b0;
        send_now = 1'b0;
        set_in('{2'b00, 2'b00, 2'b01, 2'b01, 6'h00, 2'b00, 8'h05});
        repeat (3) tick();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h00);
        exp_cnt = 0;

        // First frame after release
        rst_n = 1'b1;
        wait_frame(0, b, ok, gap);
        exp_cnt++;
        check("first_shape", 32'(ok), 32'd1);
        check("first_gap", 32'(gap), 32'd1);
        check("first_byte", 32'(b), 32'h05);
        check("first_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        for (int v = 0; v < 8; v++) begin
            set_in(vecs[v]);
            wait_frame(0, b, ok, gap);
            exp_cnt++;
            check($sformatf("vec%0d_shape", v), 32'(ok), 32'd1);
            check($sformatf("vec%0d_gap", v), 32'(gap), 32'd1);
            check($sformatf("vec%0d_byte", v), 32'(b), 32'(vecs[v].exp));
            check($sformatf("vec%0d_tx_byte", v), 32'(tx_byte), 32'(vecs[v].exp));
            check($sformatf("vec%0d_frame_cnt", v), 32'(frame_cnt), 32'(exp_cnt));
        end

        // Input change mid-frame: current frame intact, one follow-up frame
        set_in('{2'b00, 2'b00, 2'b01, 2'b01, 6'h00, 2'b00, 8'h05});
        wait_frame(1, b, ok, gap);
        exp_cnt++;
        check("midchg_shape", 32'(ok), 32'd1);
        check("midchg_byte", 32'(b), 32'h05);
        wait_frame(0, b, ok, gap);
        exp_cnt++;
        check("midchg_next_gap", 32'(gap), 32'd1);
        check("midchg_next_byte", 32'(b), 32'h06);
        check("midchg_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        quiet(30, "midchg_no_extra");

        // send_now pulses during a frame collapse to one extra frame
        send_now = 1'b1;
        tick();
        send_now = 1'b0;
        wait_frame(2, b, ok, gap);
        exp_cnt++;
        check("sendnow_gap", 32'(gap), 32'd0);
        check("sendnow_byte", 32'(b), 32'h06);
        wait_frame(0, b, ok, gap);
        exp_cnt++;
        check("sendnow_extra_gap", 32'(gap), 32'd1);
        check("sendnow_extra_shape", 32'(ok), 32'd1);
        check("sendnow_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        quiet(30, "sendnow_no_extra");

        // Periodic resend: START to START spacing equals RPT
        mode_sel = 2'b11;
        wait_frame(0, b, ok, gap);
        exp_cnt++;
        check("rpt_first_byte", 32'(b), 32'hC0);
        for (int r = 0; r < 2; r++) begin
            wait_frame(0, b, ok, gap);
            exp_cnt++;
            check($sformatf("rpt%0d_spacing", r), 32'(FRAME + gap), 32'(RPT));
            check($sformatf("rpt%0d_byte", r), 32'(b), 32'hC0);
        end
        check("rpt_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Reset in data bit 4 aborts the frame
        mode_sel = 2'b10;
        func_sel = 2'b01;
        gap = 0;
        while (busy !== 1'b1 && gap < 10) begin
            tick();
            gap++;
        end
        check("abort_started", 32'(busy), 32'd1);
        repeat (5 * CLKS + 1) tick();
        rst_n = 1'b0;
        tick();
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'h00);
        check("abort_tx_byte", 32'(tx_byte), 32'h00);
        tick();
        rst_n = 1'b1;
        wait_frame(0, b, ok, gap);
        check("restart_shape", 32'(ok), 32'd1);
        check("restart_gap", 32'(gap), 32'd1);
        check("restart_byte", 32'(b), 32'h81);
        check("restart_frame_cnt", 32'(frame_cnt), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/zigbee_cmd_tx.md
ZIGBEE_CMD_TX -- requirements
Module: zigbee_cmd_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clk_50M cycles per UART bit (9600 baud at 50 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 2500000, cycles between periodic resends (50 ms).
REQ-003 clk_50M  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 mode_sel  input  2  command class: 00 drive, 01 speed-set, 10 function, 11 autonomous.
REQ-006 sub_mode  input  2  drive-class sub-mode: 00 remote, 01 obstacle-avoid.
REQ-007 steer  input  2  00 straight, 01 right, 10 left.
REQ-008 drive  input  2  00 stop, 01 forward, 10 reverse.
REQ-009 speed_set  input  6  initial speed for speed-set class.
REQ-010 func_sel  input  2  function class: 00 line-track, 01 wall-follow, 10 park, 11 roam.
REQ-011 send_now  input  1  single-cycle pulse forcing one transmission.
REQ-012 txd  output  1  UART 8N1 serial line to Zigbee module, idle high.
REQ-013 busy  output  1  high from start-bit entry to end of stop bit.
REQ-014 tx_byte  output  8  byte currently or most recently transmitted.
REQ-015 frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-016 Command byte cmd shall be combinational from inputs: class 00 -> {00, sub_mode, steer, drive}; 01 -> {01, speed_set}; 10 -> {10, 0000, func_sel}; 11 -> {11, 000000}.
REQ-017 Trigger events: cmd != last_sent, send_now high, or repeat counter reaching REPEAT_CYCLES-1.
REQ-018 Trigger in IDLE shall enter START next cycle; trigger while busy shall set pending, serviced on the cycle after STOP ends.
REQ-019 Multiple triggers during one frame shall collapse into one pending frame.
REQ-020 At IDLE->START, cmd shall be latched into shift register, tx_byte and last_sent; later input changes shall not alter that frame.
REQ-021 FSM states IDLE, START, DATA, STOP; each bit state shall hold exactly CLKS_PER_BIT cycles via bit-timer 0..CLKS_PER_BIT-1.
REQ-022 START drives txd=0; DATA drives bits LSB first, 8 bits, bit index 0..7; STOP drives txd=1; IDLE drives txd=1.
REQ-023 Frame length shall be 10*CLKS_PER_BIT cycles from START entry to IDLE return.
REQ-024 frame_cnt shall increment on the final cycle of STOP.
REQ-025 Repeat counter shall clear on every START entry and otherwise count in all states, saturating at REPEAT_CYCLES-1 until a frame starts.
REQ-026 Invalid drive code 11 or steer 11 shall be encoded unmodified; receiver treats them as stop/straight.
REQ-027 Pending flag shall clear on START entry.

Reset
REQ-028 rst_n low at a rising edge shall force: state IDLE, txd=1, busy=0, tx_byte=0, frame_cnt=0, last_sent=0, bit/repeat timers 0, pending=1.
REQ-029 Reset mid-frame shall abort immediately; txd returns high on the next edge, no partial completion counted.
REQ-030 First frame after reset release shall start within 2 cycles (pending=1).

Verification
REQ-031 Reset release, mode_sel=00, sub_mode=00, steer=01, drive=01 -> frame 0x05 on txd: low 5208 cycles, bits 1,0,1,0,0,0,0,0, high stop; frame_cnt=1.
REQ-032 mode_sel=01, speed_set=15 while idle -> next frame 0x4F; tx_byte=0x4F; busy high exactly 52080 cycles.
REQ-033 Change drive 01->10 at bit 3 of a frame -> current frame unchanged; exactly one following frame 0x06 after stop bit.
REQ-034 Static inputs 0xC0 for 120 ms -> resend every 2500000 cycles from prior START; frame_cnt advances by 2.
REQ-035 send_now pulsed 3 times during one busy frame -> only one extra frame.
REQ-036 rst_n low at DATA bit 4 -> txd=1, busy=0, frame_cnt=0 next cycle; full frame restarts after release.
